// File: rtl/seg7_scan_if.sv
// seg7_scan_if: scanned 7-seg lines (seg/dp/an) plus the decoded frame results
interface seg7_scan_if;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [15:0] digits;
  logic        frame_valid;
  logic [3:0]  amount_q;
  logic        amount_none;
  logic        glyph_err;
  logic        stale;
  modport master (output seg, dp, an, input digits, frame_valid, amount_q, amount_none, glyph_err, stale);
  modport slave (input seg, dp, an, output digits, frame_valid, amount_q, amount_none, glyph_err, stale);
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: debounces scanned 7-seg lines, rebuilds 4 digits, decodes amount (ports: clk, rst_n, bus.slave)
module seg7_scan_decoder #(
  parameter int STABLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input logic       clk,
  input logic       rst_n,
  seg7_scan_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {SCAN, DWELL, HELD, PUBLISH} state_t;
  state_t st, st_nx;
  logic [1:0] idx, aidx;
  logic [6:0] sseg;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic [15:0] regs, digits;
  logic [3:0] mask, amount_q, q_nx;
  logic legal, same, load, capture, publish, frame_valid, amount_none, glyph_err, err, base;
  function automatic logic [3:0] glyph(input logic [6:0] s);
    case (s)
      7'b1000000: glyph = 4'h0;
      7'b1111001: glyph = 4'h1;
      7'b0100100: glyph = 4'h2;
      7'b0110000: glyph = 4'h3;
      7'b0011001: glyph = 4'h4;
      7'b0010010: glyph = 4'h5;
      7'b0000010: glyph = 4'h6;
      7'b1111000: glyph = 4'h7;
      7'b0000000: glyph = 4'h8;
      7'b0010000: glyph = 4'h9;
      7'b1111111: glyph = 4'hA;
      7'b0111111: glyph = 4'hB;
      default:    glyph = 4'hF;
    endcase
  endfunction
  function automatic logic bad_code(input logic [3:0] c);
    bad_code = c == 4'hF || c == 4'hB;
  endfunction
  always_comb begin
    legal = $countones(~bus.an) == 1;
    aidx = !bus.an[3] ? 2'd3 : !bus.an[2] ? 2'd2 : !bus.an[1] ? 2'd1 : 2'd0;
    same = legal && aidx == idx && bus.seg == sseg;
    capture = st == DWELL && same && cnt == CW'(STABLE_CYC - 1);
    publish = st == HELD && mask == 4'hF;
    st_nx = st;
    load = 1'b0;
    case (st)
      SCAN: begin
        st_nx = legal ? DWELL : SCAN;
        load = legal;
      end
      DWELL: begin
        st_nx = !legal ? SCAN : capture ? HELD : DWELL;
        load = legal && !same;
      end
      HELD: begin
        st_nx = publish ? PUBLISH : !legal ? SCAN : !same ? DWELL : HELD;
        load = !publish && legal && !same;
      end
      default: st_nx = HELD;
    endcase
  end
  // amount is derived from the captured registers so it lands together with digits on publish
  always_comb begin
    err = bad_code(regs[15:12]) || bad_code(regs[11:8]) || bad_code(regs[7:4]) || bad_code(regs[3:0]);
    base = (regs[15:12] == 4'h0 || regs[15:12] == 4'hA) && regs[7:4] == 4'h0 && regs[3:0] == 4'h0;
    q_nx = err ? 4'b0 : {4{base}} & {regs[11:8] == 4'd4, regs[11:8] == 4'd3, regs[11:8] == 4'd2, regs[11:8] == 4'd1};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= SCAN;
      idx <= 2'd0;
      sseg <= 7'h7F;
      cnt <= '0;
      tcnt <= '0;
      regs <= 16'hAAAA;
      mask <= 4'h0;
      digits <= 16'hAAAA;
      frame_valid <= 1'b0;
      amount_q <= 4'h0;
      amount_none <= 1'b0;
      glyph_err <= 1'b0;
    end else begin
      st <= st_nx;
      if (load) begin
        idx <= aidx;
        sseg <= bus.seg;
        cnt <= CW'(1);
      end else if (st == DWELL && same) begin
        cnt <= cnt + 1'b1;
      end
      if (capture) begin
        regs[idx*4 +: 4] <= glyph(sseg);
        mask[idx] <= 1'b1;
      end
      frame_valid <= publish;
      if (publish) begin
        digits <= regs;
        amount_q <= q_nx;
        amount_none <= !err && q_nx == 4'b0;
        glyph_err <= err;
        mask <= 4'h0;
        tcnt <= '0;
      end else if (tcnt != TW'(TIMEOUT_CYC)) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end
  assign bus.digits = digits;
  assign bus.frame_valid = frame_valid;
  assign bus.amount_q = amount_q;
  assign bus.amount_none = amount_none;
  assign bus.glyph_err = glyph_err;
  assign bus.stale = tcnt == TW'(TIMEOUT_CYC);
endmodule
